// File: rtl/ktop_burst_req_gen.sv
// ============================================================================
// Module  : ktop_burst_req_gen
// Purpose : Splits a byte-sized read transfer into AXI AR bursts with an
//           outstanding-burst limit and a single-cycle completion pulse.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ktop_burst_req_gen #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_LENGTH_WIDTH    = 32,
    parameter int C_BURST_LEN       = 64,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]   ctrl_addr_offset,
    input  logic [C_LENGTH_WIDTH-1:0] ctrl_xfer_size_in_bytes,
    output logic                      ctrl_done,
    output logic                      arvalid,
    input  logic                      arready,
    output logic [C_ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]                arlen,
    input  logic                      burst_done,
    output logic [7:0]                outstanding
);

    localparam int C_BYTES  = C_DATA_WIDTH / 8;
    localparam int C_LOG_B  = $clog2(C_BYTES);
    localparam int C_BEAT_W = C_LENGTH_WIDTH + 1;
    localparam logic [C_ADDR_WIDTH-1:0] C_ADDR_STEP = C_ADDR_WIDTH'(C_BURST_LEN * C_BYTES);
    localparam logic [C_ADDR_WIDTH-1:0] C_ADDR_MASK = ~C_ADDR_WIDTH'(C_BYTES - 1);
    localparam logic [C_BEAT_W-1:0]     C_BL_BEATS  = C_BEAT_W'(C_BURST_LEN);
    localparam logic [7:0]              C_MAX_OUT   = 8'(C_MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_done;
    logic                      w_done_nxt;
    logic [C_ADDR_WIDTH-1:0]   r_addr;
    logic [C_BEAT_W-1:0]       r_rem;
    logic [7:0]                r_outstanding;
    logic [7:0]                w_out_nxt;
    logic [C_BEAT_W-1:0]       w_beats;
    logic [C_BEAT_W-1:0]       w_burst_beats;
    logic [C_BEAT_W-1:0]       w_rem_after;
    logic                      w_hs;

    // One extra bit on the beat count keeps ceil(size/B) exact for the largest size.
    assign w_beats       = ({1'b0, ctrl_xfer_size_in_bytes} + C_BEAT_W'(C_BYTES - 1)) >> C_LOG_B;
    assign w_burst_beats = (r_rem >= C_BL_BEATS) ? C_BL_BEATS : r_rem;
    assign w_rem_after   = r_rem - w_burst_beats;

    assign arvalid     = (r_state == S_ISSUE) && (r_outstanding < C_MAX_OUT);
    assign araddr      = r_addr;
    assign arlen       = (r_rem == '0) ? 8'd0 : 8'(w_burst_beats - C_BEAT_W'(1));
    assign outstanding = r_outstanding;
    assign ctrl_done   = r_done;
    assign w_hs        = arvalid & arready;

    always_comb begin
        w_out_nxt = r_outstanding;
        if (w_hs && !burst_done) begin
            w_out_nxt = r_outstanding + 8'd1;
        end else if (!w_hs && burst_done && (r_outstanding != 8'd0)) begin
            w_out_nxt = r_outstanding - 8'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ctrl_start) begin
                    if (w_beats == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (w_hs && (w_rem_after == '0)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_out_nxt == 8'd0) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_done        <= 1'b0;
            r_addr        <= '0;
            r_rem         <= '0;
            r_outstanding <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_done        <= w_done_nxt;
            r_outstanding <= w_out_nxt;
            if ((r_state == S_IDLE) && ctrl_start) begin
                r_addr <= ctrl_addr_offset & C_ADDR_MASK;
                r_rem  <= w_beats;
            end else if (w_hs) begin
                r_addr <= r_addr + C_ADDR_STEP;
                r_rem  <= w_rem_after;
            end
        end
    end

endmodule

`default_nettype wire
